// File: rtl/triangle_sweep32.sv
// rtl/triangle_sweep32.sv - programmable triangle-wave generator with slope flags and turnaround pulses
module triangle_sweep32 #(
   parameter int DAC_WIDTH        = 32,
   parameter int AXIS_TDATA_WIDTH = 32,
   parameter int HOLD_CYCLES      = 4
) (
   input  logic                          slow_clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic                          cfg_load,
   input  logic        [DAC_WIDTH-1:0]   cfg_step,
   input  logic signed [DAC_WIDTH-1:0]   cfg_max,
   input  logic signed [DAC_WIDTH-1:0]   cfg_min,
   output logic [AXIS_TDATA_WIDTH-1:0]   dac_dat_a,
   output logic                          rising,
   output logic                          falling,
   output logic                          at_peak,
   output logic                          at_valley,
   output logic                          cfg_err,
   output logic [15:0]                   period_cnt
);

   localparam int EW = DAC_WIDTH + 2;
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, UP, HOLD_TOP, DOWN, HOLD_BOT} state_t;

   state_t                      state_q, state_d;
   logic signed [DAC_WIDTH-1:0] value_q, value_d;
   logic        [DAC_WIDTH-1:0] sh_step, act_step;
   logic signed [DAC_WIDTH-1:0] sh_max, sh_min, act_max, act_min;
   logic                        pending_q;
   logic [7:0]                  hold_q, hold_d;
   logic [15:0]                 period_q;
   logic                        peak_d, valley_d, commit;
   logic                        cfg_ok;

   // Extended by two bits so value +/- step can never wrap before the clamp test.
   logic signed [EW-1:0] val_x, step_x, max_x, min_x, up_sum, dn_diff;

   assign val_x   = EW'(value_q);
   assign step_x  = EW'(act_step);
   assign max_x   = EW'(act_max);
   assign min_x   = EW'(act_min);
   assign up_sum  = val_x + step_x;
   assign dn_diff = val_x - step_x;

   assign cfg_ok     = (cfg_max > cfg_min) && (cfg_step != '0);
   assign dac_dat_a  = AXIS_TDATA_WIDTH'(value_q);
   assign period_cnt = period_q;

   always_comb begin
      state_d  = state_q;
      value_d  = value_q;
      hold_d   = hold_q;
      peak_d   = 1'b0;
      valley_d = 1'b0;
      commit   = 1'b0;
      if (en) begin
         case (state_q)
            IDLE: begin
               value_d = sh_min;
               commit  = 1'b1;
               state_d = UP;
            end
            UP: begin
               if (up_sum >= max_x) begin
                  value_d = act_max;
                  peak_d  = 1'b1;
                  hold_d  = 8'd0;
                  if (HOLD_CYCLES == 0) state_d = DOWN;
                  else                  state_d = HOLD_TOP;
               end else begin
                  value_d = up_sum[DAC_WIDTH-1:0];
               end
            end
            HOLD_TOP: begin
               if (hold_q == HOLD_LAST) state_d = DOWN;
               else                     hold_d  = hold_q + 8'd1;
            end
            DOWN: begin
               // Clamp to the old min; a pending config takes over from here on.
               if (dn_diff <= min_x) begin
                  value_d  = act_min;
                  valley_d = 1'b1;
                  commit   = pending_q;
                  hold_d   = 8'd0;
                  if (HOLD_CYCLES == 0) state_d = UP;
                  else                  state_d = HOLD_BOT;
               end else begin
                  value_d = dn_diff[DAC_WIDTH-1:0];
               end
            end
            HOLD_BOT: begin
               if (hold_q == HOLD_LAST) state_d = UP;
               else                     hold_d  = hold_q + 8'd1;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge slow_clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         value_q   <= '0;
         hold_q    <= 8'd0;
         rising    <= 1'b0;
         falling   <= 1'b0;
         at_peak   <= 1'b0;
         at_valley <= 1'b0;
         cfg_err   <= 1'b0;
         period_q  <= 16'd0;
         pending_q <= 1'b0;
         sh_step   <= DAC_WIDTH'(1);
         sh_max    <= '0;
         sh_min    <= '0;
         act_step  <= DAC_WIDTH'(1);
         act_max   <= '0;
         act_min   <= '0;
      end else begin
         state_q   <= state_d;
         value_q   <= value_d;
         hold_q    <= hold_d;
         rising    <= value_d > value_q;
         falling   <= value_d < value_q;
         at_peak   <= peak_d;
         at_valley <= valley_d;
         if (valley_d) period_q <= period_q + 16'd1;
         if (commit) begin
            act_step <= sh_step;
            act_max  <= sh_max;
            act_min  <= sh_min;
         end
         // A load on the commit edge becomes the next pending config.
         if (cfg_load && cfg_ok) begin
            sh_step   <= cfg_step;
            sh_max    <= cfg_max;
            sh_min    <= cfg_min;
            pending_q <= 1'b1;
            cfg_err   <= 1'b0;
         end else begin
            if (commit)   pending_q <= 1'b0;
            if (cfg_load) cfg_err   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_triangle_sweep32.sv
// tb/tb_triangle_sweep32.sv - randomized and directed bench for triangle_sweep32 against a behavioural model
module tb_triangle_sweep32;

   localparam int HOLD = 2;

   logic        slow_clk = 1'b0;
   logic        rst, en, cfg_load;
   logic [31:0] cfg_step, cfg_max, cfg_min;
   logic [31:0] dac_dat_a;
   logic        rising, falling, at_peak, at_valley, cfg_err;
   logic [15:0] period_cnt;

   int n_checks = 0;
   int n_errors = 0;

   triangle_sweep32 #(.DAC_WIDTH(32), .AXIS_TDATA_WIDTH(32), .HOLD_CYCLES(HOLD)) dut (
      .slow_clk  (slow_clk),
      .rst       (rst),
      .en        (en),
      .cfg_load  (cfg_load),
      .cfg_step  (cfg_step),
      .cfg_max   (cfg_max),
      .cfg_min   (cfg_min),
      .dac_dat_a (dac_dat_a),
      .rising    (rising),
      .falling   (falling),
      .at_peak   (at_peak),
      .at_valley (at_valley),
      .cfg_err   (cfg_err),
      .period_cnt(period_cnt)
   );

   always #5 slow_clk = ~slow_clk;

   typedef enum {P_IDLE, P_UP, P_HT, P_DN, P_HB} phase_e;

   phase_e m_phase;
   longint m_val, m_sstep, m_smax, m_smin, m_astep, m_amax, m_amin;
   bit     m_pend, m_err, m_rise, m_fall, m_peak, m_valley;
   int     m_hold, m_per;

   function automatic longint sx(input logic [31:0] v);
      return longint'($signed(v));
   endfunction

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model(input bit r, input bit e, input bit l,
                        input logic [31:0] st, input logic [31:0] mx, input logic [31:0] mn);
      longint old;
      if (!r) begin
         m_phase = P_IDLE; m_val = 0; m_hold = 0; m_per = 0;
         m_sstep = 1; m_smax = 0; m_smin = 0; m_astep = 1; m_amax = 0; m_amin = 0;
         m_pend = 0; m_err = 0; m_rise = 0; m_fall = 0; m_peak = 0; m_valley = 0;
         return;
      end
      old = m_val; m_peak = 0; m_valley = 0;
      if (e) begin
         case (m_phase)
            P_IDLE: begin
               m_astep = m_sstep; m_amax = m_smax; m_amin = m_smin;
               m_val = m_smin; m_pend = 0; m_phase = P_UP;
            end
            P_UP: begin
               if (m_val + m_astep >= m_amax) begin
                  m_val = m_amax; m_peak = 1; m_hold = 0;
                  m_phase = (HOLD == 0) ? P_DN : P_HT;
               end else m_val = m_val + m_astep;
            end
            P_HT: begin
               m_hold++;
               if (m_hold == HOLD) m_phase = P_DN;
            end
            P_DN: begin
               if (m_val - m_astep <= m_amin) begin
                  m_val = m_amin; m_valley = 1; m_hold = 0;
                  m_per = (m_per + 1) & 16'hFFFF;
                  if (m_pend) begin
                     m_astep = m_sstep; m_amax = m_smax; m_amin = m_smin; m_pend = 0;
                  end
                  m_phase = (HOLD == 0) ? P_UP : P_HB;
               end else m_val = m_val - m_astep;
            end
            P_HB: begin
               m_hold++;
               if (m_hold == HOLD) m_phase = P_UP;
            end
            default: m_phase = P_IDLE;
         endcase
      end
      if (l) begin
         if (sx(mx) > sx(mn) && st != 0) begin
            m_sstep = longint'(st); m_smax = sx(mx); m_smin = sx(mn);
            m_pend = 1; m_err = 0;
         end else m_err = 1;
      end
      m_rise = m_val > old;
      m_fall = m_val < old;
   endtask

   task automatic cycle(input bit r, input bit e, input bit l,
                        input logic [31:0] st, input logic [31:0] mx, input logic [31:0] mn);
      logic [31:0] e_dac;
      rst = r; en = e; cfg_load = l; cfg_step = st; cfg_max = mx; cfg_min = mn;
      @(posedge slow_clk);
      model(r, e, l, st, mx, mn);
      #1;
      e_dac = m_val[31:0];
      check("dac_dat_a", dac_dat_a, e_dac);
      check("rising", rising, m_rise);
      check("falling", falling, m_fall);
      check("at_peak", at_peak, m_peak);
      check("at_valley", at_valley, m_valley);
      check("cfg_err", cfg_err, m_err);
      check("period_cnt", period_cnt, m_per);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle(1, 1, 0, 0, 0, 0);
   endtask

   logic [31:0] exp_seq [14];
   logic [31:0] rs, rmx, rmn;
   int          budget;

   initial begin
      exp_seq = '{32'd0, 32'd3, 32'd6, 32'd9, 32'd10, 32'd10, 32'd10,
                  32'd7, 32'd4, 32'd1, 32'd0, 32'd0, 32'd0, 32'd3};

      // Defaults: max == min == 0, clamps every leg, never a slope flag.
      cycle(0, 0, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 0, 0);
      check("reset_dac", dac_dat_a, 0);
      run(12);

      // Nominal example sequence.
      cycle(0, 0, 0, 0, 0, 0);
      cycle(1, 0, 1, 32'd3, 32'd10, 32'd0);
      for (int i = 0; i < 14; i++) begin
         cycle(1, 1, 0, 0, 0, 0);
         check("example_seq", dac_dat_a, exp_seq[i]);
      end

      // Invalid load, then a valid one clearing the error.
      cycle(1, 1, 1, 32'd3, 32'd5, 32'd5);
      run(3);
      cycle(1, 1, 1, 32'd0, 32'd20, 32'd0);
      run(2);
      cycle(1, 1, 1, 32'd3, 32'd10, 32'd0);

      // Mid-sweep step change on a rising leg.
      budget = 40;
      while (m_phase != P_UP && budget > 0) begin cycle(1, 1, 0, 0, 0, 0); budget--; end
      check("reach_up", budget > 0, 1);
      cycle(1, 1, 1, 32'd5, 32'd10, 32'd0);
      run(40);

      // Pause for 7 cycles mid-DOWN.
      budget = 40;
      while (m_phase != P_DN && budget > 0) begin cycle(1, 1, 0, 0, 0, 0); budget--; end
      check("reach_down", budget > 0, 1);
      for (int i = 0; i < 7; i++) cycle(1, 0, 0, 0, 0, 0);
      run(20);

      // Preload the period counter just short of wrap.
      dut.period_q = 16'hFFFE;
      m_per = 16'hFFFE;
      run(50);
      check("period_wrapped", m_per < 16'hFFFE, 1);

      // Full signed range.
      cycle(0, 0, 0, 0, 0, 0);
      cycle(1, 0, 1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000);
      run(30);

      // Randomized configs, loads and enable gaps.
      for (int i = 0; i < 4000; i++) begin
         case ($urandom_range(0, 3))
            0:       begin rs = 32'($urandom_range(0, 6)); rmn = 32'($urandom_range(0, 100)) - 32'd50; rmx = rmn + 32'($urandom_range(0, 30)); end
            1:       begin rs = $urandom; rmx = $urandom; rmn = $urandom; end
            default: begin rs = 32'($urandom_range(1, 20)); rmn = 32'($urandom_range(0, 100)) - 32'd50; rmx = rmn + 32'($urandom_range(1, 80)); end
         endcase
         cycle($urandom_range(0, 999) != 0, $urandom_range(0, 9) != 0,
               $urandom_range(0, 19) == 0, rs, rmx, rmn);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/triangle_sweep32.md
# triangle_sweep32

Triangle-wave velocity-drive generator feeding the DAC path. It produces a signed sawtooth-free triangle between programmable minimum and maximum values with a programmable step and dwell at each turnaround. It also flags the current slope as `rising`/`falling` and pulses on each peak and valley. It is the source end of the slope-detection path: the ADC-side slope detector, fed this waveform, must reproduce these flags.

## Interface
- `DAC_WIDTH`, 32: width of the signed waveform value.
- `AXIS_TDATA_WIDTH`, 32: width of the output data bus; value sign-extended into it.
- `HOLD_CYCLES`, 4: extra cycles the value dwells at max/min (0 to 255).
- `slow_clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `en`  in  1  run enable; 0 freezes the generator.
- `cfg_load`  in  1  one-cycle pulse; captures `cfg_*` into the shadow registers.
- `cfg_step`  in  DAC_WIDTH  unsigned step per cycle.
- `cfg_max`  in  DAC_WIDTH  signed upper bound.
- `cfg_min`  in  DAC_WIDTH  signed lower bound.
- `dac_dat_a`  out  AXIS_TDATA_WIDTH  registered waveform, sign-extended.
- `rising`  out  1  dac value increased on this edge.
- `falling`  out  1  dac value decreased on this edge.
- `at_peak`  out  1  one-cycle pulse on the edge the value clamps to max.
- `at_valley`  out  1  one-cycle pulse on the edge the value clamps to min.
- `cfg_err`  out  1  sticky: last `cfg_load` was rejected.
- `period_cnt`  out  16  completed periods (valley count), wraps 0xFFFF→0.

## Operation
- **Reset (`rst`=0):**
  - All outputs are 0 and the state is IDLE.
  - Shadow and active config reset to step=1, max=0, min=0.
  - `pending` is cleared.
- **Config load:** `cfg_load` is valid only if `cfg_max > cfg_min` (signed) and `cfg_step != 0`.
  - Valid load: written to shadow, `pending` set, `cfg_err` cleared.
  - Invalid load: ignored, `cfg_err` set.
- **States:** IDLE, UP, HOLD_TOP, DOWN, HOLD_BOT.
- **IDLE:** when `en`=1, commit the shadow config to active, load value := min, clear `pending`, and go to UP. No flag pulses on this edge.
  - `rising`/`falling` on this edge follow the general comparison rule against the previous value (0).
- **UP:**
  - next = value + step, computed in DAC_WIDTH+2 bits signed, so no overflow.
  - If next ≥ max: value := max, `at_peak`=1, go to HOLD_TOP (or DOWN if HOLD_CYCLES=0).
- **DOWN:**
  - next = value − step.
  - If next ≤ min: value := min, `at_valley`=1, `period_cnt`++, go to HOLD_BOT (or UP if HOLD_CYCLES=0).
- **HOLD_TOP / HOLD_BOT:** value is constant for HOLD_CYCLES edges, then the state moves to DOWN / UP.
- **Pending config:** committed only on the valley clamp edge.
  - The value clamps to the old min on that edge.
  - New step and max apply from the next UP edge; the new min applies on the following down leg.
  - If value ≥ new max on an UP edge, the value clamps to the new max; the flags follow the comparison rule.
- **Slope flags (all states):** `rising` = (new value > old value) and `falling` = (new value < old value).
  - Both are registered on the same edge as `dac_dat_a`.
  - They are never both 1.
- **`en`=0 outside IDLE:** state, value and hold counter freeze; `rising`/`falling`/`at_peak`/`at_valley` are 0. Resume continues exactly where it stopped.
- **Simultaneous events:**
  - `cfg_load` on the valley edge: the old shadow is committed, and the new load becomes pending for the next valley.
  - `rst`=0 overrides everything mid-sweep.

## Timing
- Value, flags and pulses update together on one edge; there is no extra pipeline. Latency from state to output is 1 cycle.
- Max is held for HOLD_CYCLES+1 consecutive output cycles (clamp edge plus dwell); the same applies to min.
- Example: min=0, max=10, step=3, HOLD_CYCLES=2. Output from start: 0,3,6,9,10,10,10,7,4,1,0,0,0,3…
  - `rising` is 1 on 3,6,9 and the first 10.
  - `falling` is 1 on 7,4,1 and the first 0.
- Output fed through the slope detector gives the same `rising`/`falling` sequence delayed by 3 `slow_clk` cycles.

## Test plan
- **Reset:** reset, then `en`=1 with defaults (max=min=0) → IDLE exits.
  - First UP edge clamps at once: `dac_dat_a`=0 and `at_peak`=1; then it dwells, and `at_valley`=1 on the next DOWN edge.
  - No `rising`/`falling` ever asserts.
- **Nominal sweep:** load min=0, max=10, step=3, HOLD=2 → exact sequence above. `period_cnt`=1 after the first valley, and `at_peak`/`at_valley` are one cycle wide.
- **Invalid config:** load max=5, min=5 → `cfg_err`=1 and the sweep is unchanged. A following valid load clears `cfg_err`.
- **Mid-sweep load:** load step=5 during a rising leg → the old step continues until the valley and the new step starts on the next UP edge. No output jump greater than the step.
- **Extreme range:** min=0x80000000, max=0x7FFFFFFF, step=0x7FFFFFFF → clamps at max/min without wrap, and the sign of `dac_dat_a` stays correct.
- **Enable pause and wrap:** toggle `en` low for 7 cycles mid-DOWN → the value is frozen and the flags are 0; the sequence resumes unchanged. Force `period_cnt` wrap over 65536 periods → 0xFFFF→0.
